uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Two-requester burst arbiter in front of a UART transmitter.
//               The optional burst idle timeout is enabled with the macro
//               UART_TX_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
    parameter int DW          = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0_valid,
    input  logic [DW-1:0] i_req0_data,
    input  logic          i_req0_last,
    output logic          o_req0_ready,
    input  logic          i_req1_valid,
    input  logic [DW-1:0] i_req1_data,
    input  logic          i_req1_last,
    output logic          o_req1_ready,
    output logic          o_tx_valid,
    output logic [DW-1:0] o_tx_data,
    input  logic          i_tx_ready,
    output logic [1:0]    o_grant,
    output logic          o_timeout
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_OWN0 = 2'd1;
    localparam logic [1:0] c_ST_OWN1 = 2'd2;

    if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 65535)) begin : g_bad_timeout_cyc
        $error("uart_tx_arb: TIMEOUT_CYC must be within 2..65535");
    end

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_prio;
    logic          w_prio_nxt;
    logic          w_own0;
    logic          w_own1;
    logic          w_tx_valid;
    logic [DW-1:0] w_tx_data;
    logic          w_last;
    logic          w_xfer;
    logic          w_tmo_hit;

    assign w_own0 = (r_state == c_ST_OWN0);
    assign w_own1 = (r_state == c_ST_OWN1);

    // Owner's channel is passed straight through to the transmitter.
    always_comb begin
        w_tx_valid = 1'b0;
        w_tx_data  = '0;
        w_last     = 1'b0;
        if (w_own0) begin
            w_tx_valid = i_req0_valid;
            w_tx_data  = i_req0_data;
            w_last     = i_req0_last;
        end else if (w_own1) begin
            w_tx_valid = i_req1_valid;
            w_tx_data  = i_req1_data;
            w_last     = i_req1_last;
        end
    end

    assign w_xfer       = w_tx_valid & i_tx_ready;
    assign o_tx_valid   = w_tx_valid;
    assign o_tx_data    = w_tx_data;
    assign o_req0_ready = w_own0 & i_tx_ready;
    assign o_req1_ready = w_own1 & i_tx_ready;
    assign o_grant      = {w_own1, w_own0};

    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        case (r_state)
            c_ST_IDLE: begin
                if (i_req0_valid && (!i_req1_valid || !r_prio)) begin
                    w_state_nxt = c_ST_OWN0;
                end else if (i_req1_valid) begin
                    w_state_nxt = c_ST_OWN1;
                end
            end
            c_ST_OWN0, c_ST_OWN1: begin
                // Releasing hands preference to the other requester.
                if ((w_xfer && w_last) || w_tmo_hit) begin
                    w_state_nxt = c_ST_IDLE;
                    w_prio_nxt  = w_own0;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_ST_IDLE;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_tmo_cnt;
    logic        r_timeout;

    // A coinciding transfer always wins over the timeout.
    assign w_tmo_hit = (w_own0 | w_own1) & ~w_xfer & (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_tmo_hit;
            if (w_xfer || (w_state_nxt != r_state) || !(w_own0 || w_own1)) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_tmo_hit = 1'b0;
    assign o_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arb
// Description : Directed vector bench for uart_tx_arb; the timeout sequence
//               follows the UART_TX_ARB_TIMEOUT_EN build setting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_last, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req1_data;
    logic       tx_valid, tx_ready, timeout;
    logic [7:0] tx_data;
    logic [1:0] grant;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .DW          (8),
        .TIMEOUT_CYC (8)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (req0_valid),
        .i_req0_data  (req0_data),
        .i_req0_last  (req0_last),
        .o_req0_ready (req0_ready),
        .i_req1_valid (req1_valid),
        .i_req1_data  (req1_data),
        .i_req1_last  (req1_last),
        .o_req1_ready (req1_ready),
        .o_tx_valid   (tx_valid),
        .o_tx_data    (tx_data),
        .i_tx_ready   (tx_ready),
        .o_grant      (grant),
        .o_timeout    (timeout)
    );

    typedef struct {
        logic       rst;
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       rdy;
        logic [1:0] g;
        logic       tv;
        logic [7:0] td;
        logic       r0;
        logic       r1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst_i, v0, input logic [7:0] d0,
                                input logic l0, v1, input logic [7:0] d1,
                                input logic l1, rdy, input logic [1:0] g,
                                input logic tv, input logic [7:0] td,
                                input logic r0, r1);
        vec_t v;
        v.rst = rst_i; v.v0 = v0; v.d0 = d0; v.l0 = l0;
        v.v1 = v1; v.d1 = d1; v.l1 = l1; v.rdy = rdy;
        v.g = g; v.tv = tv; v.td = td; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    task automatic drive(input logic rst_i, v0, input logic [7:0] d0,
                         input logic l0, v1, input logic [7:0] d1,
                         input logic l1, rdy);
        rst = rst_i;
        req0_valid = v0; req0_data = d0; req0_last = l0;
        req1_valid = v1; req1_data = d1; req1_last = l1;
        tx_ready = rdy;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        // reset state
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 2'd0, 0, 8'h00, 0, 0));
        // single requester 0x41,0x42,0x43
        vecs.push_back(mk(0, 1, 8'h41, 0, 0, 8'h00, 0, 1, 2'd0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'h41, 0, 0, 8'h00, 0, 1, 2'd1, 1, 8'h41, 1, 0));
        vecs.push_back(mk(0, 1, 8'h42, 0, 0, 8'h00, 0, 1, 2'd1, 1, 8'h42, 1, 0));
        vecs.push_back(mk(0, 1, 8'h43, 1, 0, 8'h00, 0, 1, 2'd1, 1, 8'h43, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'd0, 0, 8'h00, 0, 0));
        // priority is now 1: req1 wins the tie, then req0
        vecs.push_back(mk(0, 1, 8'h55, 1, 1, 8'h66, 1, 1, 2'd0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'h55, 1, 1, 8'h66, 1, 1, 2'd2, 1, 8'h66, 0, 1));
        vecs.push_back(mk(0, 1, 8'h55, 1, 1, 8'h66, 1, 1, 2'd0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'h55, 1, 1, 8'h66, 1, 1, 2'd1, 1, 8'h55, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'd0, 0, 8'h00, 0, 0));
        // contention from reset: req0 burst, dead cycle, req1 burst
        vecs.push_back(mk(1, 1, 8'hA0, 0, 1, 8'hB0, 1, 1, 2'd0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA0, 0, 1, 8'hB0, 1, 1, 2'd0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'hA0, 0, 1, 8'hB0, 1, 1, 2'd1, 1, 8'hA0, 1, 0));
        vecs.push_back(mk(0, 1, 8'hA1, 1, 1, 8'hB0, 1, 1, 2'd1, 1, 8'hA1, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'hB0, 1, 1, 2'd0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'hB0, 1, 1, 2'd2, 1, 8'hB0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'd0, 0, 8'h00, 0, 0));
        // backpressure for 5 cycles with req1 waiting
        vecs.push_back(mk(0, 1, 8'hC0, 0, 0, 8'h00, 0, 1, 2'd0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'hC0, 0, 0, 8'h00, 0, 1, 2'd1, 1, 8'hC0, 1, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 8'hC1, 0, 1, 8'hD0, 1, 0, 2'd1, 1, 8'hC1, 0, 0));
        vecs.push_back(mk(0, 1, 8'hC1, 0, 1, 8'hD0, 1, 1, 2'd1, 1, 8'hC1, 1, 0));
        vecs.push_back(mk(0, 1, 8'hC2, 1, 1, 8'hD0, 1, 1, 2'd1, 1, 8'hC2, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'hD0, 1, 1, 2'd0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'hD0, 1, 1, 2'd2, 1, 8'hD0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'd0, 0, 8'h00, 0, 0));
        // owner drops valid mid-burst and keeps the grant
        vecs.push_back(mk(0, 1, 8'h10, 0, 0, 8'h00, 0, 1, 2'd0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'h10, 0, 0, 8'h00, 0, 1, 2'd1, 1, 8'h10, 1, 0));
        vecs.push_back(mk(0, 0, 8'h11, 0, 1, 8'h20, 1, 1, 2'd1, 0, 8'h11, 1, 0));
        vecs.push_back(mk(0, 1, 8'h11, 1, 1, 8'h20, 1, 1, 2'd1, 1, 8'h11, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'h20, 1, 1, 2'd0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'h20, 1, 1, 2'd2, 1, 8'h20, 0, 1));
        // set priority 1, then reset during a req1 burst after 2 bytes
        vecs.push_back(mk(0, 1, 8'h90, 1, 0, 8'h00, 0, 1, 2'd0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'h90, 1, 0, 8'h00, 0, 1, 2'd1, 1, 8'h90, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'hE0, 0, 1, 2'd0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'hE0, 0, 1, 2'd2, 1, 8'hE0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'hE1, 0, 1, 2'd2, 1, 8'hE1, 0, 1));
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'hE2, 0, 1, 2'd2, 1, 8'hE2, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'd0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'hF0, 1, 1, 8'hE2, 0, 1, 2'd0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'hF0, 1, 1, 8'hE2, 0, 1, 2'd1, 1, 8'hF0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'd0, 0, 8'h00, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].v0, vecs[i].d0, vecs[i].l0,
                  vecs[i].v1, vecs[i].d1, vecs[i].l1, vecs[i].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d.grant", i),    32'(grant),      32'(vecs[i].g));
            chk($sformatf("vec%0d.tx_valid", i), 32'(tx_valid),   32'(vecs[i].tv));
            chk($sformatf("vec%0d.tx_data", i),  32'(tx_data),    32'(vecs[i].td));
            chk($sformatf("vec%0d.ready0", i),   32'(req0_ready), 32'(vecs[i].r0));
            chk($sformatf("vec%0d.ready1", i),   32'(req1_ready), 32'(vecs[i].r1));
            chk($sformatf("vec%0d.timeout", i),  32'(timeout),    32'd0);
            next_cycle();
        end

`ifdef UART_TX_ARB_TIMEOUT_EN
        // req1 sends one byte then goes silent; req0 waits with a 1-byte burst
        drive(0, 0, 8'h00, 0, 1, 8'h77, 0, 1);
        @(negedge clk);
        chk("tmo.pre_grant", 32'(grant), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("tmo.grant1", 32'(grant), 32'd2);
        chk("tmo.data", 32'(tx_data), 32'h77);
        next_cycle();
        drive(0, 1, 8'h88, 1, 0, 8'h00, 0, 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("tmo.hold%0d.grant", k), 32'(grant), 32'd2);
            chk($sformatf("tmo.hold%0d.timeout", k), 32'(timeout), 32'd0);
            chk($sformatf("tmo.hold%0d.ready0", k), 32'(req0_ready), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("tmo.pulse", 32'(timeout), 32'd1);
        chk("tmo.idle", 32'(grant), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("tmo.pulse_end", 32'(timeout), 32'd0);
        chk("tmo.req0_grant", 32'(grant), 32'd1);
        chk("tmo.req0_data", 32'(tx_data), 32'h88);
        next_cycle();
        drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        @(negedge clk);
        chk("tmo.final_idle", 32'(grant), 32'd0);
`else
        // owner stalls 5000 cycles: grant is held and no timeout appears
        drive(0, 1, 8'h31, 0, 0, 8'h00, 0, 1);
        @(negedge clk);
        chk("stall.pre_grant", 32'(grant), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("stall.grant", 32'(grant), 32'd1);
        chk("stall.data", 32'(tx_data), 32'h31);
        next_cycle();
        drive(0, 0, 8'h00, 0, 1, 8'h40, 1, 1);
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d.timeout", k), 32'(timeout), 32'd0);
            chk($sformatf("stall%0d.grant", k), 32'(grant), 32'd1);
            chk($sformatf("stall%0d.ready1", k), 32'(req1_ready), 32'd0);
            next_cycle();
        end
        drive(0, 1, 8'h32, 1, 1, 8'h40, 1, 1);
        @(negedge clk);
        chk("stall.last_data", 32'(tx_data), 32'h32);
        chk("stall.last_grant", 32'(grant), 32'd1);
        next_cycle();
        drive(0, 0, 8'h00, 0, 1, 8'h40, 1, 1);
        @(negedge clk);
        chk("stall.dead", 32'(grant), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("stall.req1_grant", 32'(grant), 32'd2);
        chk("stall.req1_data", 32'(tx_data), 32'h40);
        next_cycle();
        drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        @(negedge clk);
        chk("stall.final_idle", 32'(grant), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
